// File: rtl/modulation_pkg.sv
// ---------------------------------------------------------------------------
// modulation_pkg
// Shared types and constants for the modulation engine and the sine table:
//   mod_t          - modulation selector encoding (values 4..15 = plain carrier)
//   state_t        - sequencing FSM states
//   QPSK_QUAD_*    - Gray-mapped QPSK phase offsets, in quarter turns
//   qpsk_quadrant  - symbol -> quarter-turn offset
//   extract_symbol - symbol width depends on the selected modulation
// ---------------------------------------------------------------------------
package modulation_pkg;

   typedef enum logic [3:0] {
      MOD_ASK  = 4'd0,
      MOD_FSK  = 4'd1,
      MOD_BPSK = 4'd2,
      MOD_QPSK = 4'd3
   } mod_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Gray mapping: adjacent phases differ in one symbol bit.
   localparam logic [1:0] QPSK_QUAD_00 = 2'd0;  // 0 deg
   localparam logic [1:0] QPSK_QUAD_01 = 2'd1;  // 90 deg
   localparam logic [1:0] QPSK_QUAD_11 = 2'd2;  // 180 deg
   localparam logic [1:0] QPSK_QUAD_10 = 2'd3;  // 270 deg

   function automatic logic [1:0] qpsk_quadrant(input logic [1:0] sym);
      logic [1:0] quad;
      case (sym)
         2'b00:   quad = QPSK_QUAD_00;
         2'b01:   quad = QPSK_QUAD_01;
         2'b11:   quad = QPSK_QUAD_11;
         default: quad = QPSK_QUAD_10;
      endcase
      return quad;
   endfunction

   function automatic logic [1:0] extract_symbol(input logic [3:0] sel,
                                                 input logic [1:0] lfsr_lo);
      return (sel == MOD_QPSK) ? lfsr_lo : {1'b0, lfsr_lo[0]};
   endfunction

endpackage

// File: rtl/modulation_engine_sine_lut.sv
// ---------------------------------------------------------------------------
// sine_lut
// Synchronous sine ROM, one-cycle read latency. Contents are computed at
// elaboration: entry k = round((2^(SAMPLE_W-1)-1) * sin(2*pi*k / 2^LUT_ADDR_W)).
// Ports:
//   clk  - clock
//   addr - table index (top phase bits)
//   data - signed sample, registered
// ---------------------------------------------------------------------------
module sine_lut #(
   parameter int unsigned LUT_ADDR_W = 8,
   parameter int unsigned SAMPLE_W   = 12
) (
   input  logic                       clk,
   input  logic [LUT_ADDR_W-1:0]      addr,
   output logic signed [SAMPLE_W-1:0] data
);

   localparam int unsigned DEPTH   = 1 << LUT_ADDR_W;
   localparam longint      DEPTH_L = longint'(DEPTH);

   // Integer-only sine so table generation does not depend on real-math
   // support in constant functions. Q30 fixed point, angle folded into
   // [0, pi/2], Taylor series to 12 terms.
   function automatic longint sine_entry(input longint k);
      longint one_q, pi_q, half, quarter, m, th, term, sum, amp, mag;
      one_q   = 64'sd1 << 30;
      pi_q    = 64'sd3373259426;
      half    = DEPTH_L / 64'sd2;
      quarter = DEPTH_L / 64'sd4;
      m       = k % half;
      if (m > quarter) begin
         m = half - m;
      end
      th   = (64'sd2 * pi_q * m) / DEPTH_L;
      term = th;
      sum  = th;
      for (int i = 1; i <= 12; i++) begin
         term = -((((term * th) / one_q) * th) / one_q) / longint'(2 * i * (2 * i + 1));
         sum  = sum + term;
      end
      amp = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
      mag = (sum * amp + one_q / 64'sd2) / one_q;
      return (k >= half) ? -mag : mag;
   endfunction

   logic signed [SAMPLE_W-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic signed [SAMPLE_W-1:0] ENTRY = SAMPLE_W'(sine_entry(longint'(k)));
      assign rom[k] = ENTRY;
   end

   always_ff @(posedge clk) begin
      data <= rom[addr];
   end

endmodule

// File: rtl/modulation_engine.sv
// ---------------------------------------------------------------------------
// modulation_engine
// Turns the LFSR bit stream into a sampled ASK/BFSK/BPSK/QPSK (or plain)
// carrier. Configuration and symbol are shadowed and only re-latched on
// symbol boundaries so the waveform never changes mid-symbol.
// Ports:
//   clk            - system clock
//   reset          - synchronous, active-high
//   enable         - run request (level); low flushes everything to idle
//   dds_increment  - carrier phase step per clock
//   symbol_div     - clocks per symbol (0 and 1 both mean one)
//   modulation_sel - 0 ASK, 1 BFSK, 2 BPSK, 3 QPSK, others plain carrier
//   lfsr_val       - symbol source, sampled at symbol boundaries
//   sample_out     - signed modulated sample (0 when not valid)
//   sample_valid   - sample_out valid
//   symbol_bits    - symbol of the current output sample
//   symbol_strobe  - first output sample of a new symbol
// Pipeline: accumulator -> effective LUT address register -> LUT register,
// so outputs trail the accumulator by two cycles.
// ---------------------------------------------------------------------------
module modulation_engine
   import modulation_pkg::*;
#(
   parameter int unsigned PHASE_W    = 32,
   parameter int unsigned LUT_ADDR_W = 8,
   parameter int unsigned SAMPLE_W   = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [PHASE_W-1:0]         dds_increment,
   input  logic [31:0]                symbol_div,
   input  logic [3:0]                 modulation_sel,
   input  logic [31:0]                lfsr_val,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid,
   output logic [1:0]                 symbol_bits,
   output logic                       symbol_strobe
);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   state_t state_q, state_d;
   logic   load, run, term;

   logic [PHASE_W-1:0] inc_q;
   logic [31:0]        div_q;
   logic [3:0]         mod_q;
   logic [1:0]         sym_q;
   logic [31:0]        cnt_q;
   logic [31:0]        div_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      load = (state_q == LOAD);
      run  = (state_q == RUN);
      term = run && (cnt_q == div_last);
   end

   // ------------------------------------------------------------------
   // Shadow registers and symbol, re-latched only at symbol boundaries
   // ------------------------------------------------------------------
   assign div_last = (div_q <= 32'd1) ? 32'd0 : div_q - 32'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         inc_q <= '0;
         div_q <= '0;
         mod_q <= '0;
         sym_q <= '0;
      end else if (load || term) begin
         inc_q <= dds_increment;
         div_q <= symbol_div;
         mod_q <= modulation_sel;
         sym_q <= extract_symbol(modulation_sel, lfsr_val[1:0]);
      end
   end

   // Only the two symbol bits are consumed.
   logic unused_lfsr;
   assign unused_lfsr = ^lfsr_val[31:2];

   // ------------------------------------------------------------------
   // Phase accumulator and symbol counter
   // ------------------------------------------------------------------
   logic [PHASE_W-1:0]    acc_q;
   logic [PHASE_W-1:0]    inc_eff;
   logic [LUT_ADDR_W-1:0] acc_addr;
   logic [LUT_ADDR_W-1:0] addr_eff;
   logic                  mute;

   always_comb begin
      inc_eff = inc_q;
      if (mod_q == MOD_FSK && sym_q[0]) begin
         inc_eff = inc_q << 1;
      end
   end

   // Phase offsets are whole quarter turns, so they only touch the bits
   // that index the table; no carry can come from the lower phase bits.
   assign acc_addr = acc_q[PHASE_W-1 -: LUT_ADDR_W];

   always_comb begin
      addr_eff = acc_addr;
      mute     = 1'b0;
      case (mod_q)
         MOD_ASK:  mute     = ~sym_q[0];
         MOD_BPSK: addr_eff = acc_addr + {~sym_q[0], {(LUT_ADDR_W - 1){1'b0}}};
         MOD_QPSK: addr_eff = acc_addr + {qpsk_quadrant(sym_q), {(LUT_ADDR_W - 2){1'b0}}};
         default:  addr_eff = acc_addr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !enable || !run) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_q + inc_eff;
         cnt_q <= term ? 32'd0 : cnt_q + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // Two-stage output pipeline
   // ------------------------------------------------------------------
   logic                  p1_valid, p1_mute, p1_strobe;
   logic [1:0]            p1_sym;
   logic [LUT_ADDR_W-1:0] p1_addr;
   logic                  p2_valid, p2_mute, p2_strobe;
   logic [1:0]            p2_sym;
   logic signed [SAMPLE_W-1:0] lut_data;

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         p1_valid  <= 1'b0;
         p1_mute   <= 1'b0;
         p1_strobe <= 1'b0;
         p1_sym    <= '0;
         p1_addr   <= '0;
         p2_valid  <= 1'b0;
         p2_mute   <= 1'b0;
         p2_strobe <= 1'b0;
         p2_sym    <= '0;
      end else begin
         p1_valid  <= run;
         p1_mute   <= mute;
         // Counter is zero exactly in the first clock of each symbol.
         p1_strobe <= run && (cnt_q == 32'd0);
         p1_sym    <= run ? sym_q : 2'b00;
         p1_addr   <= addr_eff;
         p2_valid  <= p1_valid;
         p2_mute   <= p1_mute;
         p2_strobe <= p1_strobe;
         p2_sym    <= p1_sym;
      end
   end

   sine_lut #(
      .LUT_ADDR_W (LUT_ADDR_W),
      .SAMPLE_W   (SAMPLE_W)
   ) u_sine_lut (
      .clk  (clk),
      .addr (p1_addr),
      .data (lut_data)
   );

   // ROM output is not reset, so gate it with the pipeline valid.
   assign sample_out    = (p2_valid && !p2_mute) ? lut_data : '0;
   assign sample_valid  = p2_valid;
   assign symbol_bits   = p2_sym;
   assign symbol_strobe = p2_strobe;

endmodule

// File: tb/tb_modulation_engine.sv
module tb_modulation_engine;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic [31:0]        dds_increment;
   logic [31:0]        symbol_div;
   logic [3:0]         modulation_sel;
   logic [31:0]        lfsr_val;
   logic signed [11:0] sample_out;
   logic               sample_valid;
   logic [1:0]         symbol_bits;
   logic               symbol_strobe;

   int tests = 0;
   int fails = 0;
   int ecount = 0;

   always #5 clk = ~clk;

   modulation_engine #(
      .PHASE_W    (32),
      .LUT_ADDR_W (8),
      .SAMPLE_W   (12)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .dds_increment  (dds_increment),
      .symbol_div     (symbol_div),
      .modulation_sel (modulation_sel),
      .lfsr_val       (lfsr_val),
      .sample_out     (sample_out),
      .sample_valid   (sample_valid),
      .symbol_bits    (symbol_bits),
      .symbol_strobe  (symbol_strobe)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic advance_to(input int e);
      while (ecount < e) tick();
   endtask

   // Enable rises before edge 0; after the next tick ecount == 0.
   task automatic start();
      enable = 1'b1;
      ecount = -1;
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      dds_increment  = 32'h0;
      symbol_div     = 32'd0;
      modulation_sel = 4'd0;
      lfsr_val       = 32'h0;
      tick();
      tick();
      check("rst_valid", sample_valid, 0);
      check("rst_sample", sample_out, 0);
      check("rst_bits", symbol_bits, 0);
      check("rst_strobe", symbol_strobe, 0);
      reset = 1'b0;
      tick();

      // Plain carrier, one table step per clock
      modulation_sel = 4'd4;
      dds_increment  = 32'h0100_0000;
      symbol_div     = 32'd1000;
      lfsr_val       = 32'h0;
      start();
      advance_to(2);
      check("car_valid_early", sample_valid, 0);
      advance_to(3);
      check("car_valid_first", sample_valid, 1);
      check("car_s0", sample_out, 0);
      check("car_strobe0", symbol_strobe, 1);
      advance_to(4);
      check("car_s1", sample_out, 50);
      check("car_strobe1", symbol_strobe, 0);
      advance_to(19);
      check("car_s16", sample_out, 783);
      advance_to(67);
      check("car_s64", sample_out, 2047);
      advance_to(195);
      check("car_s192", sample_out, -2047);
      advance_to(259);
      check("car_s256", sample_out, 0);
      check("car_valid_run", sample_valid, 1);
      enable = 1'b0;
      tick();
      check("drop_valid", sample_valid, 0);
      check("drop_sample", sample_out, 0);

      // BPSK, 256-clock symbols, bit 1 then bit 0
      modulation_sel = 4'd2;
      symbol_div     = 32'd256;
      lfsr_val       = 32'h1;
      start();
      advance_to(3);
      check("bpsk_s0", sample_out, 0);
      check("bpsk_bits0", symbol_bits, 1);
      advance_to(4);
      check("bpsk_s1", sample_out, 50);
      advance_to(67);
      check("bpsk_s64", sample_out, 2047);
      advance_to(100);
      lfsr_val = 32'h0;
      advance_to(258);
      check("bpsk_s255", sample_out, -50);
      check("bpsk_nostrobe", symbol_strobe, 0);
      check("bpsk_bits_hold", symbol_bits, 1);
      advance_to(259);
      check("bpsk_flip_strobe", symbol_strobe, 1);
      check("bpsk_flip_s", sample_out, 0);
      check("bpsk_flip_bits", symbol_bits, 0);
      advance_to(260);
      check("bpsk_flip_s1", sample_out, -50);
      advance_to(323);
      check("bpsk_flip_s64", sample_out, -2047);
      enable = 1'b0;
      tick();

      // QPSK, zero increment, one-clock symbols stepping 00,01,11,10
      modulation_sel = 4'd3;
      dds_increment  = 32'h0;
      symbol_div     = 32'd0;
      lfsr_val       = 32'h0;
      start();
      advance_to(1);
      lfsr_val = 32'h1;
      advance_to(2);
      lfsr_val = 32'h3;
      advance_to(3);
      lfsr_val = 32'h2;
      check("qpsk_00", sample_out, 0);
      check("qpsk_bits00", symbol_bits, 0);
      check("qpsk_strobe3", symbol_strobe, 1);
      advance_to(4);
      check("qpsk_01", sample_out, 2047);
      check("qpsk_bits01", symbol_bits, 1);
      check("qpsk_strobe4", symbol_strobe, 1);
      advance_to(5);
      check("qpsk_11", sample_out, 0);
      check("qpsk_bits11", symbol_bits, 3);
      advance_to(6);
      check("qpsk_10", sample_out, -2047);
      check("qpsk_bits10", symbol_bits, 2);
      enable = 1'b0;
      tick();

      // BFSK bit 1: doubled increment, period 128; symbol_div = 1
      modulation_sel = 4'd1;
      dds_increment  = 32'h0100_0000;
      symbol_div     = 32'd1;
      lfsr_val       = 32'h1;
      start();
      advance_to(3);
      check("fsk_s0", sample_out, 0);
      check("fsk_strobe3", symbol_strobe, 1);
      advance_to(4);
      check("fsk_s1", sample_out, 100);
      check("fsk_strobe4", symbol_strobe, 1);
      advance_to(35);
      check("fsk_s32", sample_out, 2047);
      advance_to(50);
      check("fsk_strobe50", symbol_strobe, 1);
      advance_to(67);
      check("fsk_s64", sample_out, 0);
      advance_to(99);
      check("fsk_s96", sample_out, -2047);
      enable = 1'b0;
      tick();

      // ASK bit 0, then mode and length changed mid-symbol
      modulation_sel = 4'd0;
      dds_increment  = 32'h0100_0000;
      symbol_div     = 32'd256;
      lfsr_val       = 32'h0;
      start();
      advance_to(3);
      check("ask_valid", sample_valid, 1);
      check("ask_s0", sample_out, 0);
      advance_to(67);
      check("ask_mute64", sample_out, 0);
      advance_to(101);
      modulation_sel = 4'd4;
      symbol_div     = 32'd512;
      advance_to(153);
      check("ask_mute150", sample_out, 0);
      advance_to(259);
      check("chg_strobe", symbol_strobe, 1);
      advance_to(300);
      lfsr_val = 32'h1;
      advance_to(323);
      check("chg_carrier64", sample_out, 2047);
      check("chg_bits_hold", symbol_bits, 0);
      advance_to(515);
      check("chg_div_nostrobe", symbol_strobe, 0);
      advance_to(771);
      check("chg_div_strobe", symbol_strobe, 1);
      check("chg_bits_new", symbol_bits, 1);
      advance_to(800);
      check("pre_reset_valid", sample_valid, 1);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", sample_valid, 0);
      check("mid_rst_sample", sample_out, 0);
      check("mid_rst_bits", symbol_bits, 0);
      check("mid_rst_strobe", symbol_strobe, 0);
      reset  = 1'b0;
      enable = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
